// File: rtl/regfile_sb.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | regfile_sb : 2R1W register file with a per-register busy scoreboard.   |
// | Optional same-cycle write bypass: define REGFILE_BYPASS_EN.  Rev 1.0   |
// +------------------------------------------------------------------------+
module regfile_sb #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr1,
  input  logic [$clog2(DEPTH)-1:0] rd_addr2,
  output logic [WIDTH-1:0]         rd_data1,
  output logic [WIDTH-1:0]         rd_data2,
  output logic                     rd_busy1,
  output logic                     rd_busy2,
  input  logic                     rsv_en,
  input  logic [$clog2(DEPTH)-1:0] rsv_addr,
  output logic                     rsv_ok,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   busy_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] c_zero_idx = AW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_busy;
  logic [AW:0]      r_busy_cnt;

  logic [DEPTH-1:0] w_busy_nxt;
  logic [AW:0]      w_cnt_nxt;
  logic             w_rsv_ok;
  logic             w_byp1;
  logic             w_byp2;

  // A write to the reserved index in the same cycle frees it, so WAW is fine there.
  assign w_rsv_ok = rst_n && rsv_en && !flush &&
                    (!r_busy[rsv_addr] || (wr_en && wr_addr == rsv_addr) ||
                     rsv_addr == c_zero_idx);
  assign rsv_ok   = w_rsv_ok;
  assign busy_cnt = r_busy_cnt;

`ifdef REGFILE_BYPASS_EN
  assign w_byp1 = rst_n && wr_en && wr_addr == rd_addr1 && rd_addr1 != c_zero_idx;
  assign w_byp2 = rst_n && wr_en && wr_addr == rd_addr2 && rd_addr2 != c_zero_idx;
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif

  always_comb begin
    rd_data1 = '0;
    rd_data2 = '0;
    if (w_byp1)                       rd_data1 = wr_data;
    else if (rd_addr1 != c_zero_idx)  rd_data1 = r_mem[rd_addr1];
    if (w_byp2)                       rd_data2 = wr_data;
    else if (rd_addr2 != c_zero_idx)  rd_data2 = r_mem[rd_addr2];
  end

  // The zero index is never set in r_busy, so no explicit guard is needed here.
  assign rd_busy1 = w_byp1 ? 1'b0 : r_busy[rd_addr1];
  assign rd_busy2 = w_byp2 ? 1'b0 : r_busy[rd_addr2];

  // Reservation wins over a same-cycle write-clear; flush wins over both.
  always_comb begin
    w_busy_nxt = r_busy;
    if (flush) begin
      w_busy_nxt = '0;
    end else begin
      if (wr_en)
        w_busy_nxt[wr_addr] = 1'b0;
      if (w_rsv_ok && rsv_addr != c_zero_idx)
        w_busy_nxt[rsv_addr] = 1'b1;
    end
  end

  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++)
      w_cnt_nxt = w_cnt_nxt + (AW + 1)'(w_busy_nxt[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else if (wr_en && wr_addr != c_zero_idx) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_regfile_sb : scoreboard-driven self-checking bench for regfile_sb.  |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_regfile_sb;

  localparam int WIDTH = 64;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [AW-1:0]    rd_addr1;
  logic [AW-1:0]    rd_addr2;
  logic [WIDTH-1:0] rd_data1;
  logic [WIDTH-1:0] rd_data2;
  logic             rd_busy1;
  logic             rd_busy2;
  logic             rsv_en;
  logic [AW-1:0]    rsv_addr;
  logic             rsv_ok;
  logic             flush;
  logic [AW:0]      busy_cnt;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q [$];

  regfile_sb #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok),
    .flush(flush), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en  = 1'b0;
    rsv_en = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic test_reset();
    logic [63:0] e;
    rd_addr1 = 5'd3; rd_addr2 = 5'd6;
    exp_q.push_back(64'd0); exp_q.push_back(64'd0);
    #1;
    e = exp_q.pop_front(); checks++;
    if (64'(rd_data1) !== e) begin errors++; $display("FAIL por_rd_data1: got %h want %h", rd_data1, e); end
    e = exp_q.pop_front(); checks++;
    if (64'(busy_cnt) !== e) begin errors++; $display("FAIL por_busy_cnt: got %0d want %0d", busy_cnt, e); end
    rst_n = 1'b1;
    tick();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'hDEAD;
    rsv_en = 1'b1; rsv_addr = 5'd6;
    exp_q.push_back(64'hDEAD); exp_q.push_back(64'd1);
    tick(); idle(); #1;
    e = exp_q.pop_front(); checks++;
    if (64'(rd_data1) !== e) begin errors++; $display("FAIL x3_written: got %h want %h", rd_data1, e); end
    e = exp_q.pop_front(); checks++;
    if (64'(busy_cnt) !== e) begin errors++; $display("FAIL pre_reset_cnt: got %0d want %0d", busy_cnt, e); end
    // Assert reset between clock edges: clearing must not wait for clk.
    #2; rst_n = 1'b0;
    exp_q.push_back(64'd0); exp_q.push_back(64'd0); exp_q.push_back(64'd0);
    #1;
    e = exp_q.pop_front(); checks++;
    if (64'(rd_data1) !== e) begin errors++; $display("FAIL async_rd_data1: got %h want %h", rd_data1, e); end
    e = exp_q.pop_front(); checks++;
    if (64'(busy_cnt) !== e) begin errors++; $display("FAIL async_busy_cnt: got %0d want %0d", busy_cnt, e); end
    e = exp_q.pop_front(); checks++;
    if (64'(rd_busy2) !== e) begin errors++; $display("FAIL async_rd_busy2: got %0d want %0d", rd_busy2, e); end
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'hBEEF;
    rsv_en = 1'b1; rsv_addr = 5'd8;
    exp_q.push_back(64'd0); exp_q.push_back(64'd0);
    tick();
    e = exp_q.pop_front(); checks++;
    if (64'(rd_data1) !== e) begin errors++; $display("FAIL write_in_reset: got %h want %h", rd_data1, e); end
    e = exp_q.pop_front(); checks++;
    if (64'(busy_cnt) !== e) begin errors++; $display("FAIL rsv_in_reset: got %0d want %0d", busy_cnt, e); end
    idle(); #2; rst_n = 1'b1;
    exp_q.push_back(64'd0); exp_q.push_back(64'd0);
    tick();
    e = exp_q.pop_front(); checks++;
    if (64'(rd_data1) !== e) begin errors++; $display("FAIL post_reset_data: got %h want %h", rd_data1, e); end
    e = exp_q.pop_front(); checks++;
    if (64'(busy_cnt) !== e) begin errors++; $display("FAIL post_reset_cnt: got %0d want %0d", busy_cnt, e); end
  endtask

  task automatic test_scoreboard();
    logic [63:0] e;
    rsv_en = 1'b1; rsv_addr = 5'd5;
    exp_q.push_back(64'd1);
    #1;
    e = exp_q.pop_front(); checks++;
    if (64'(rsv_ok) !== e) begin errors++; $display("FAIL rsv_x5_ok: got %0d want %0d", rsv_ok, e); end
    exp_q.push_back(64'd1); exp_q.push_back(64'd1);
    tick(); idle(); rd_addr1 = 5'd5; #1;
    e = exp_q.pop_front(); checks++;
    if (64'(rd_busy1) !== e) begin errors++; $display("FAIL x5_busy: got %0d want %0d", rd_busy1, e); end
    e = exp_q.pop_front(); checks++;
    if (64'(busy_cnt) !== e) begin errors++; $display("FAIL x5_cnt: got %0d want %0d", busy_cnt, e); end
    rsv_en = 1'b1; rsv_addr = 5'd5;
    exp_q.push_back(64'd0);
    #1;
    e = exp_q.pop_front(); checks++;
    if (64'(rsv_ok) !== e) begin errors++; $display("FAIL rsv_x5_waw: got %0d want %0d", rsv_ok, e); end
    exp_q.push_back(64'd1);
    tick(); idle(); #1;
    e = exp_q.pop_front(); checks++;
    if (64'(busy_cnt) !== e) begin errors++; $display("FAIL waw_cnt: got %0d want %0d", busy_cnt, e); end
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'h1234;
    exp_q.push_back(64'd0); exp_q.push_back(64'h1234); exp_q.push_back(64'd0);
    tick(); idle(); #1;
    e = exp_q.pop_front(); checks++;
    if (64'(busy_cnt) !== e) begin errors++; $display("FAIL x5_wb_cnt: got %0d want %0d", busy_cnt, e); end
    e = exp_q.pop_front(); checks++;
    if (64'(rd_data1) !== e) begin errors++; $display("FAIL x5_wb_data: got %h want %h", rd_data1, e); end
    e = exp_q.pop_front(); checks++;
    if (64'(rd_busy1) !== e) begin errors++; $display("FAIL x5_wb_busy: got %0d want %0d", rd_busy1, e); end
  endtask

  task automatic test_zero_reg();
    logic [63:0] e;
    rsv_en = 1'b1; rsv_addr = 5'd2;
    tick(); idle();
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'hFFFF;
    rsv_en = 1'b1; rsv_addr = 5'd31;
    exp_q.push_back(64'd1);
    #1;
    e = exp_q.pop_front(); checks++;
    if (64'(rsv_ok) !== e) begin errors++; $display("FAIL x31_rsv_ok: got %0d want %0d", rsv_ok, e); end
    exp_q.push_back(64'd0); exp_q.push_back(64'd0); exp_q.push_back(64'd1);
    tick(); idle(); rd_addr1 = 5'd31; #1;
    e = exp_q.pop_front(); checks++;
    if (64'(rd_data1) !== e) begin errors++; $display("FAIL x31_data: got %h want %h", rd_data1, e); end
    e = exp_q.pop_front(); checks++;
    if (64'(rd_busy1) !== e) begin errors++; $display("FAIL x31_busy: got %0d want %0d", rd_busy1, e); end
    e = exp_q.pop_front(); checks++;
    if (64'(busy_cnt) !== e) begin errors++; $display("FAIL x31_cnt: got %0d want %0d", busy_cnt, e); end
  endtask

  task automatic test_write_reserve();
    logic [63:0] e;
    rsv_en = 1'b1; rsv_addr = 5'd7;
    tick(); idle();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h7777;
    rsv_en = 1'b1; rsv_addr = 5'd7;
    exp_q.push_back(64'd1);
    #1;
    e = exp_q.pop_front(); checks++;
    if (64'(rsv_ok) !== e) begin errors++; $display("FAIL x7_wr_rsv_ok: got %0d want %0d", rsv_ok, e); end
    exp_q.push_back(64'h7777); exp_q.push_back(64'd1); exp_q.push_back(64'd2);
    tick(); idle(); rd_addr1 = 5'd7; #1;
    e = exp_q.pop_front(); checks++;
    if (64'(rd_data1) !== e) begin errors++; $display("FAIL x7_data: got %h want %h", rd_data1, e); end
    e = exp_q.pop_front(); checks++;
    if (64'(rd_busy1) !== e) begin errors++; $display("FAIL x7_busy: got %0d want %0d", rd_busy1, e); end
    e = exp_q.pop_front(); checks++;
    if (64'(busy_cnt) !== e) begin errors++; $display("FAIL x7_cnt: got %0d want %0d", busy_cnt, e); end
    // Retire X2 while reserving X10 in the same cycle.
    wr_en = 1'b1; wr_addr = 5'd2; wr_data = 64'h2222;
    rsv_en = 1'b1; rsv_addr = 5'd10;
    exp_q.push_back(64'h2222); exp_q.push_back(64'd0); exp_q.push_back(64'd1); exp_q.push_back(64'd2);
    tick(); idle(); rd_addr1 = 5'd2; rd_addr2 = 5'd10; #1;
    e = exp_q.pop_front(); checks++;
    if (64'(rd_data1) !== e) begin errors++; $display("FAIL ooo_x2_data: got %h want %h", rd_data1, e); end
    e = exp_q.pop_front(); checks++;
    if (64'(rd_busy1) !== e) begin errors++; $display("FAIL ooo_x2_busy: got %0d want %0d", rd_busy1, e); end
    e = exp_q.pop_front(); checks++;
    if (64'(rd_busy2) !== e) begin errors++; $display("FAIL ooo_x10_busy: got %0d want %0d", rd_busy2, e); end
    e = exp_q.pop_front(); checks++;
    if (64'(busy_cnt) !== e) begin errors++; $display("FAIL ooo_cnt: got %0d want %0d", busy_cnt, e); end
  endtask

  task automatic test_flush();
    logic [63:0] e;
    rsv_en = 1'b1; rsv_addr = 5'd1;
    tick();
    rsv_addr = 5'd2;
    tick(); idle();
    exp_q.push_back(64'd4);
    #1;
    e = exp_q.pop_front(); checks++;
    if (64'(busy_cnt) !== e) begin errors++; $display("FAIL pre_flush_cnt: got %0d want %0d", busy_cnt, e); end
    flush = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd4;
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 64'hC0DE;
    exp_q.push_back(64'd0);
    #1;
    e = exp_q.pop_front(); checks++;
    if (64'(rsv_ok) !== e) begin errors++; $display("FAIL flush_rsv_ok: got %0d want %0d", rsv_ok, e); end
    exp_q.push_back(64'd0); exp_q.push_back(64'hC0DE); exp_q.push_back(64'd0);
    tick(); idle(); rd_addr1 = 5'd12; rd_addr2 = 5'd4; #1;
    e = exp_q.pop_front(); checks++;
    if (64'(busy_cnt) !== e) begin errors++; $display("FAIL flush_cnt: got %0d want %0d", busy_cnt, e); end
    e = exp_q.pop_front(); checks++;
    if (64'(rd_data1) !== e) begin errors++; $display("FAIL flush_wr_data: got %h want %h", rd_data1, e); end
    e = exp_q.pop_front(); checks++;
    if (64'(rd_busy2) !== e) begin errors++; $display("FAIL flush_x4_busy: got %0d want %0d", rd_busy2, e); end
  endtask

  task automatic test_bypass();
    logic [63:0] e;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'h1111;
    rsv_en = 1'b1; rsv_addr = 5'd9;
    tick(); idle();
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'hABCD;
    rd_addr1 = 5'd9; rd_addr2 = 5'd9;
`ifdef REGFILE_BYPASS_EN
    exp_q.push_back(64'hABCD); exp_q.push_back(64'd0);
`else
    exp_q.push_back(64'h1111); exp_q.push_back(64'd1);
`endif
    #1;
    e = exp_q.pop_front(); checks++;
    if (64'(rd_data1) !== e) begin errors++; $display("FAIL byp_same_data: got %h want %h", rd_data1, e); end
    e = exp_q.pop_front(); checks++;
    if (64'(rd_busy2) !== e) begin errors++; $display("FAIL byp_same_busy: got %0d want %0d", rd_busy2, e); end
    exp_q.push_back(64'hABCD); exp_q.push_back(64'd0);
    tick(); idle(); #1;
    e = exp_q.pop_front(); checks++;
    if (64'(rd_data2) !== e) begin errors++; $display("FAIL byp_next_data: got %h want %h", rd_data2, e); end
    e = exp_q.pop_front(); checks++;
    if (64'(rd_busy1) !== e) begin errors++; $display("FAIL byp_next_busy: got %0d want %0d", rd_busy1, e); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] e;
    logic [63:0] mm [DEPTH];
    logic        mb [DEPTH];
    logic        ok;
    int          cnt;
    #2; rst_n = 1'b0;
    #2; rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin mm[i] = '0; mb[i] = 1'b0; end
    for (int n = 0; n < 300; n++) begin
      wr_en    = 1'($urandom_range(0, 1));
      wr_addr  = 5'($urandom_range(0, 31));
      wr_data  = {$urandom(), $urandom()};
      rsv_en   = ($urandom_range(0, 3) != 0);
      rsv_addr = 5'($urandom_range(0, 31));
      flush    = ($urandom_range(0, 15) == 0);
      ok = rsv_en && !flush &&
           (!mb[rsv_addr] || (wr_en && wr_addr == rsv_addr) || rsv_addr == 5'd31);
      exp_q.push_back(64'(ok));
      #1;
      e = exp_q.pop_front(); checks++;
      if (64'(rsv_ok) !== e) begin errors++; $display("FAIL rnd_rsv_ok[%0d]: got %0d want %0d", n, rsv_ok, e); end
      if (wr_en && wr_addr != 5'd31) mm[wr_addr] = wr_data;
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) mb[i] = 1'b0;
      end else begin
        if (wr_en) mb[wr_addr] = 1'b0;
        if (ok && rsv_addr != 5'd31) mb[rsv_addr] = 1'b1;
      end
      cnt = 0;
      for (int i = 0; i < DEPTH; i++) cnt += int'(mb[i]);
      exp_q.push_back(64'(cnt));
      tick(); idle();
      rd_addr1 = 5'($urandom_range(0, 31));
      rd_addr2 = 5'($urandom_range(0, 31));
      exp_q.push_back(mm[rd_addr1]);
      exp_q.push_back(64'(mb[rd_addr2]));
      #1;
      e = exp_q.pop_front(); checks++;
      if (64'(busy_cnt) !== e) begin errors++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", n, busy_cnt, e); end
      e = exp_q.pop_front(); checks++;
      if (64'(rd_data1) !== e) begin errors++; $display("FAIL rnd_data[%0d]: got %h want %h", n, rd_data1, e); end
      e = exp_q.pop_front(); checks++;
      if (64'(rd_busy2) !== e) begin errors++; $display("FAIL rnd_busy[%0d]: got %0d want %0d", n, rd_busy2, e); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    wr_addr = '0; wr_data = '0; rsv_addr = '0;
    rd_addr1 = '0; rd_addr2 = '0;
    #12;
    test_reset();
    test_scoreboard();
    test_zero_reg();
    test_write_reserve();
    test_flush();
    test_bypass();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
